jtag_tap_bscan: RTL and testbench

Parametrised IEEE 1149.1-style test access port that generalises the team's fixed 3-bit-IR, 248-cell TAP wrapper: a TAP state machine, instruction register, bypass, optional IDCODE and a boundary-scan register are combined in one block. Width and opcode set are set by parameters. The block sits between the chip JTAG pins and the core wrapper, which uses `test_mode`/`bsr_update_o` to override core I/O. It adds INTEST, IDCODE, visible TAP state and a decoded-instruction output.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_tap_fsm.sv | 54 +++++
 rtl/jtag_tap_bscan.sv | 116 +++++++++++
 tb/tb_jtag_tap_bscan.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encodings, opcode helpers and IR capture value
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam int OPC_EXTEST = 0;
    localparam int OPC_SAMPLE = 1;
    localparam int OPC_IDCODE = 2;
    localparam int OPC_INTEST = 3;

    // Low bits of the value loaded into the IR shift register in Capture-IR;
    // upper bits are zero-extended to the IR width.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    // BYPASS is the all-ones opcode of whatever IR width is in use
    function automatic logic [31:0] opc_bypass(input int ir_size);
        return 32'((64'd1 << ir_size) - 64'd1);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller with decoded IR/DR strobes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       reset,
    input  logic       TMS,
    output tap_state_e state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e state_next;

    // State register; reset overrides TMS
    always_ff @(posedge TCK) begin
        state <= reset ? TLR : state_next;
    end

    // Standard TMS transitions and per-state action strobes
    always_comb begin
        state_next = state;
        capture_ir = state == CAP_IR;
        shift_ir   = state == SH_IR;
        update_ir  = state == UPD_IR;
        capture_dr = state == CAP_DR;
        shift_dr   = state == SH_DR;
        update_dr  = state == UPD_DR;
        case (state)
            TLR:      state_next = TMS ? TLR      : RTI;
            RTI:      state_next = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_next = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_next = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_next = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_next = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_next = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_next = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_next = TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_next = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_next = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_next = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_next = TMS ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_bscan.sv
// jtag_tap_bscan: parametrised TAP with IR, BYPASS, BSR and optional IDCODE (macro JTAG_IDCODE_EN)
module jtag_tap_bscan
    import jtag_pkg::*;
#(
    parameter int          BSR_SIZE     = 248,
    parameter int          IR_SIZE      = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                TCK,
    input  logic                reset,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_en,
    input  logic [BSR_SIZE-1:0] bsr_capture_i,
    output logic [BSR_SIZE-1:0] bsr_update_o,
    output logic                test_mode,
    output logic [IR_SIZE-1:0]  instr_o,
    output logic [3:0]          tap_state_o
);

    localparam logic [IR_SIZE-1:0] OP_EXTEST = IR_SIZE'(OPC_EXTEST);
    localparam logic [IR_SIZE-1:0] OP_SAMPLE = IR_SIZE'(OPC_SAMPLE);
    localparam logic [IR_SIZE-1:0] OP_IDCODE = IR_SIZE'(OPC_IDCODE);
    localparam logic [IR_SIZE-1:0] OP_INTEST = IR_SIZE'(OPC_INTEST);
    localparam logic [IR_SIZE-1:0] OP_BYPASS = IR_SIZE'(opc_bypass(IR_SIZE));
    localparam logic [IR_SIZE-1:0] IR_CAP    = IR_SIZE'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_SIZE-1:0] INSTR_RST = OP_IDCODE;
`else
    localparam logic [IR_SIZE-1:0] INSTR_RST = OP_BYPASS;
`endif

    tap_state_e          state;
    logic                capture_ir, shift_ir, update_ir;
    logic                capture_dr, shift_dr, update_dr;
    logic [IR_SIZE-1:0]  ir_shift;
    logic [BSR_SIZE-1:0] bsr_shift;
    logic                bypass_reg;
    logic                sel_bsr, sel_byp, dr_tdo;

    jtag_tap_fsm u_fsm (
        .TCK        (TCK),
        .reset      (reset),
        .TMS        (TMS),
        .state      (state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tap_state_o = state;
    assign sel_bsr     = instr_o == OP_EXTEST || instr_o == OP_SAMPLE || instr_o == OP_INTEST;
    assign test_mode   = instr_o == OP_EXTEST || instr_o == OP_INTEST;
    assign tdo_en      = shift_ir || shift_dr;
    assign TDO         = shift_ir ? ir_shift[0] : shift_dr & dr_tdo;

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_reg;
    logic        sel_id;

    assign sel_id  = instr_o == OP_IDCODE;
    assign sel_byp = !sel_bsr && !sel_id;
    assign dr_tdo  = sel_bsr ? bsr_shift[0] : sel_id ? idcode_reg[0] : bypass_reg;

    // IDCODE register; bit 0 always captures 1 as the ID marker
    always_ff @(posedge TCK) begin
        if (reset) idcode_reg <= '0;
        else if (capture_dr && sel_id) idcode_reg <= {IDCODE_VALUE[31:1], 1'b1};
        else if (shift_dr && sel_id) idcode_reg <= {TDI, idcode_reg[31:1]};
    end
`else
    logic unused_idcode;

    assign unused_idcode = ^IDCODE_VALUE;
    assign sel_byp       = !sel_bsr;
    assign dr_tdo        = sel_bsr ? bsr_shift[0] : bypass_reg;
`endif

    // Instruction shift register
    always_ff @(posedge TCK) begin
        if (reset) ir_shift <= '0;
        else if (capture_ir) ir_shift <= IR_CAP;
        else if (shift_ir) ir_shift <= {TDI, ir_shift[IR_SIZE-1:1]};
    end

    // Active instruction; Test-Logic-Reset keeps reloading the reset opcode
    always_ff @(posedge TCK) begin
        if (reset || state == TLR) instr_o <= INSTR_RST;
        else if (update_ir) instr_o <= ir_shift;
    end

    // Single-bit bypass register
    always_ff @(posedge TCK) begin
        if (reset) bypass_reg <= 1'b0;
        else if (capture_dr && sel_byp) bypass_reg <= 1'b0;
        else if (shift_dr && sel_byp) bypass_reg <= TDI;
    end

    // Boundary-scan shift chain, bit 0 nearest TDO
    always_ff @(posedge TCK) begin
        if (reset) bsr_shift <= '0;
        else if (capture_dr && sel_bsr) bsr_shift <= bsr_capture_i;
        else if (shift_dr && sel_bsr) bsr_shift <= BSR_SIZE'({TDI, bsr_shift} >> 1);
    end

    // Boundary-scan update latch driving pins/core in test mode
    always_ff @(posedge TCK) begin
        if (reset) bsr_update_o <= '0;
        else if (update_dr && sel_bsr) bsr_update_o <= bsr_shift;
    end

endmodule

// File: tb/tb_jtag_tap_bscan.sv
// tb_jtag_tap_bscan: directed scans with hand-computed expectations for jtag_tap_bscan
module tb_jtag_tap_bscan;

    logic       TCK = 1'b0;
    logic       reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO, tdo_en, test_mode;
    logic [7:0] bsr_capture_i = 8'hAA;
    logic [7:0] bsr_update_o;
    logic [3:0] instr_o, tap_state_o;

    int checks = 0;
    int failures = 0;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] INSTR_RST = 4'h2;
`else
    localparam logic [3:0] INSTR_RST = 4'hF;
`endif

    jtag_tap_bscan #(
        .BSR_SIZE     (8),
        .IR_SIZE      (4),
        .IDCODE_VALUE (32'h1000_0000)
    ) dut (
        .TCK           (TCK),
        .reset         (reset),
        .TMS           (TMS),
        .TDI           (TDI),
        .TDO           (TDO),
        .tdo_en        (tdo_en),
        .bsr_capture_i (bsr_capture_i),
        .bsr_update_o  (bsr_update_o),
        .test_mode     (test_mode),
        .instr_o       (instr_o),
        .tap_state_o   (tap_state_o)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic scan_ir(input logic [3:0] val, output logic [3:0] out);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        check("ir_tdo_en", 32'(tdo_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            out[i] = TDO;
            tick(i == 3, val[i]);
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    task automatic scan_dr(input logic [31:0] val, input int n, output logic [31:0] out,
                           output logic [7:0] upd_in_upd);
        out = '0;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < n; i++) begin
            out[i] = TDO;
            tick(i == n - 1, val[i]);
        end
        tick(1, 0);
        upd_in_upd = bsr_update_o;
        tick(0, 0);
    endtask

    logic [3:0]  ir_out;
    logic [31:0] dr_out;
    logic [7:0]  upd;

    initial begin
        tick(1, 0);
        reset = 1'b0;
        check("rst_state", 32'(tap_state_o), 32'hF);
        check("rst_instr", 32'(instr_o), 32'(INSTR_RST));
        check("rst_tdo", 32'(TDO), 32'd0);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_test_mode", 32'(test_mode), 32'd0);
        check("rst_bsr_upd", 32'(bsr_update_o), 32'h00);
        tick(0, 0);
        check("rti_state", 32'(tap_state_o), 32'hC);

        scan_ir(4'hF, ir_out);
        check("ir_capture", 32'(ir_out), 32'h1);
        check("bypass_instr", 32'(instr_o), 32'hF);
        scan_dr(32'b1101, 4, dr_out, upd);
        check("bypass_delay", dr_out, 32'b1010);

        scan_ir(4'h2, ir_out);
        check("idcode_instr", 32'(instr_o), 32'h2);
        check("idcode_test_mode", 32'(test_mode), 32'd0);
`ifdef JTAG_IDCODE_EN
        scan_dr(32'h0, 32, dr_out, upd);
        check("idcode_value", dr_out, 32'h1000_0001);
`else
        scan_dr(32'b11, 2, dr_out, upd);
        check("idcode_as_bypass", dr_out, 32'b10);
`endif
        check("idcode_bsr_hold", 32'(bsr_update_o), 32'h00);

        scan_ir(4'h1, ir_out);
        check("sample_test_mode", 32'(test_mode), 32'd0);
        scan_dr(32'hA5, 8, dr_out, upd);
        check("sample_capture", dr_out, 32'hAA);
        check("sample_upd_at_upddr", 32'(upd), 32'h00);
        check("sample_preload", 32'(bsr_update_o), 32'hA5);

        scan_ir(4'h0, ir_out);
        check("extest_test_mode", 32'(test_mode), 32'd1);
        check("extest_preloaded", 32'(bsr_update_o), 32'hA5);
        scan_dr(32'h3C, 8, dr_out, upd);
        check("extest_capture", dr_out, 32'hAA);
        check("extest_upd_at_upddr", 32'(upd), 32'hA5);
        check("extest_update", 32'(bsr_update_o), 32'h3C);

        scan_ir(4'h3, ir_out);
        check("intest_test_mode", 32'(test_mode), 32'd1);

        scan_ir(4'h7, ir_out);
        check("unknown_instr", 32'(instr_o), 32'h7);
        check("unknown_test_mode", 32'(test_mode), 32'd0);
        scan_dr(32'hFF, 8, dr_out, upd);
        check("unknown_is_bypass", dr_out, 32'hFE);
        check("bypass_bsr_hold", 32'(bsr_update_o), 32'h3C);

        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        check("shdr_state", 32'(tap_state_o), 32'h2);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("tms5_state", 32'(tap_state_o), 32'hF);
        tick(1, 0);
        check("tlr_instr", 32'(instr_o), 32'(INSTR_RST));
        check("tlr_tdo", 32'(TDO), 32'd0);

        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 1);
        check("shir_state", 32'(tap_state_o), 32'hA);
        tick(0, 1);
        reset = 1'b1;
        tick(0, 0);
        reset = 1'b0;
        check("abort_state", 32'(tap_state_o), 32'hF);
        check("abort_instr", 32'(instr_o), 32'(INSTR_RST));
        check("abort_tdo_en", 32'(tdo_en), 32'd0);
        check("abort_bsr_upd", 32'(bsr_update_o), 32'h00);
        tick(0, 0);
        check("abort_rti_instr", 32'(instr_o), 32'(INSTR_RST));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
